// File: rtl/bj_hand_register_if.sv
// Card-append port for bj_hand_register: load request, hand clear, and the
// registered hand view (slots, totals, status flags).
interface bj_hand_register_if #(
  parameter int SLOTS = 8
);
  localparam int CNT_W = $clog2(SLOTS * 11 + 1);
  localparam int NC_W  = $clog2(SLOTS + 1);

  // Handshake: a card transfers on a rising CLK edge where LD=1, RDY=1, NEW=0
  // and D is a card code (0..12). LD without RDY, or with D in 13..15, is
  // refused and answered with a one-cycle ERR pulse. NEW beats LD silently.
  logic                 LD;
  logic [3:0]           D;
  logic                 NEW;
  logic                 RDY;
  logic [4*SLOTS-1:0]   Q;
  logic [CNT_W-1:0]     CNT;
  logic [NC_W-1:0]      NCARDS;
  logic                 FULL;
  logic                 BUST;
  logic                 SOFT;
  logic                 BJ;
  logic                 ERR;

  modport master (
    output LD, D, NEW,
    input  RDY, Q, CNT, NCARDS, FULL, BUST, SOFT, BJ, ERR
  );

  modport slave (
    input  LD, D, NEW,
    output RDY, Q, CNT, NCARDS, FULL, BUST, SOFT, BJ, ERR
  );
endinterface

// File: rtl/bj_hand_register.sv
// Blackjack hand register: stores up to SLOTS card codes and keeps the hand
// total and status flags registered alongside them. Define BJ_SOFT_ACE_EN to
// let one ace count as 11 when that does not bust the hand.
module bj_hand_register #(
  parameter int SLOTS      = 8,
  parameter int BUST_LIMIT = 21
) (
  input  logic               CLK,
  input  logic               CLR,
  bj_hand_register_if.slave  bus
);
  localparam int CNT_W = $clog2(SLOTS * 11 + 1);
  localparam int NC_W  = $clog2(SLOTS + 1);
  localparam int EW    = CNT_W + 1;

  typedef logic [EW-1:0] ext_t;
  localparam ext_t LIMIT = ext_t'(BUST_LIMIT);

  logic [4*SLOTS-1:0] q_r, q_n;
  logic [NC_W-1:0]    nc_r, nc_n;
  logic [CNT_W-1:0]   hard_r, hard_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic               full_r, full_n;
  logic               bust_r, bust_n;
  logic               soft_r, soft_n;
  logic               bj_r, bj_n;
  logic               err_r, err_n;
  logic               rdy;
`ifdef BJ_SOFT_ACE_EN
  logic               ace_r, ace_n;
  ext_t               hard_ext;
`endif

  function automatic logic [3:0] card_val(input logic [3:0] code);
    logic [3:0] v;
    case (code)
      4'd1:                          v = 4'd1;
      4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9:        v = code;
      4'd0, 4'd10, 4'd11, 4'd12:     v = 4'd10;
      default:                       v = 4'd0;
    endcase
    return v;
  endfunction

  assign rdy = !full_r && !bust_r;

  always_comb begin
    q_n    = q_r;
    nc_n   = nc_r;
    hard_n = hard_r;
    cnt_n  = cnt_r;
    full_n = full_r;
    bust_n = bust_r;
    soft_n = soft_r;
    bj_n   = bj_r;
    err_n  = 1'b0;
`ifdef BJ_SOFT_ACE_EN
    ace_n    = ace_r;
    hard_ext = '0;
`endif
    if (bus.NEW) begin
      q_n    = '1;
      nc_n   = '0;
      hard_n = '0;
      cnt_n  = '0;
      full_n = 1'b0;
      bust_n = 1'b0;
      soft_n = 1'b0;
      bj_n   = 1'b0;
`ifdef BJ_SOFT_ACE_EN
      ace_n  = 1'b0;
`endif
    end else if (bus.LD) begin
      if (rdy && bus.D <= 4'd12) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (nc_r == NC_W'(i)) q_n[4*i +: 4] = bus.D;
        end
        nc_n   = nc_r + 1'b1;
        hard_n = hard_r + CNT_W'(card_val(bus.D));
        cnt_n  = hard_n;
        soft_n = 1'b0;
`ifdef BJ_SOFT_ACE_EN
        // Only one ace can ever be promoted: two would add 20 and bust.
        ace_n    = ace_r | (bus.D == 4'd1);
        hard_ext = ext_t'(hard_n);
        if (ace_n && (hard_ext + ext_t'(10)) <= LIMIT) begin
          cnt_n  = CNT_W'(hard_ext + ext_t'(10));
          soft_n = 1'b1;
        end
`endif
        bust_n = ext_t'(cnt_n) > LIMIT;
        full_n = nc_n == NC_W'(SLOTS);
        bj_n   = (nc_n == NC_W'(2)) && (cnt_n == CNT_W'(21));
      end else begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q_r    <= '1;
      nc_r   <= '0;
      hard_r <= '0;
      cnt_r  <= '0;
      full_r <= 1'b0;
      bust_r <= 1'b0;
      soft_r <= 1'b0;
      bj_r   <= 1'b0;
      err_r  <= 1'b0;
`ifdef BJ_SOFT_ACE_EN
      ace_r  <= 1'b0;
`endif
    end else begin
      q_r    <= q_n;
      nc_r   <= nc_n;
      hard_r <= hard_n;
      cnt_r  <= cnt_n;
      full_r <= full_n;
      bust_r <= bust_n;
      soft_r <= soft_n;
      bj_r   <= bj_n;
      err_r  <= err_n;
`ifdef BJ_SOFT_ACE_EN
      ace_r  <= ace_n;
`endif
    end
  end

  assign bus.RDY    = rdy;
  assign bus.Q      = q_r;
  assign bus.CNT    = cnt_r;
  assign bus.NCARDS = nc_r;
  assign bus.FULL   = full_r;
  assign bus.BUST   = bust_r;
  assign bus.SOFT   = soft_r;
  assign bus.BJ     = bj_r;
  assign bus.ERR    = err_r;
endmodule
